// File: rtl/encap_pkg.sv
// ---------------------------------------------------------------------------
// encap_pkg
// Shared types and helpers for the encapsulator ingress path.
//   arb_state_t       : packet arbiter states (IDLE / PASS / DRAIN)
//   beats_for_length  : number of bus beats needed to carry a byte count
// ---------------------------------------------------------------------------
package encap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // arbitration cycle, nothing flows
    PASS  = 2'd1,  // granted requester streams through to the encapsulator
    DRAIN = 2'd2   // truncated packet: swallow beats until its tlast
  } arb_state_t;

  // Ceiling division: a partial last beat still occupies a whole beat.
  function automatic int beats_for_length(input int bytes, input int bus_bytes);
    return (bytes + bus_bytes - 1) / bus_bytes;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker. The search starts one position after
// last_grant and wraps, so the most recent winner has lowest priority.
// Ports:
//   req        in  NUM_REQ   request vector
//   last_grant in  ID_WIDTH  index of the previous winner
//   winner     out ID_WIDTH  chosen index (0 when nothing requests)
//   any_valid  out 1         at least one request is present
// ---------------------------------------------------------------------------
module rr_priority_pick #(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_valid
);

  // Two descending sweeps, last write wins: the first sweep leaves the
  // lowest requesting index at or below last_grant (the wrap-around choice),
  // the second overrides it with the lowest index above last_grant if any.
  always_comb begin
    winner    = '0;
    any_valid = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_WIDTH'(i) <= last_grant)) winner = ID_WIDTH'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_WIDTH'(i) > last_grant)) winner = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/encap_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// encap_ingress_arbiter
// Packet-granular round-robin arbiter sharing the encapsulator input stream
// between NUM_REQ tenant AXI-Stream sources. The winner index is stamped on
// tid; packets longer than MAX_BEATS are cut (forced tlast) and the rest of
// the packet is drained so one tenant cannot stall the shared encapsulator.
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   req_t{data,dest,keep}    flattened per-requester payload, slice i = req i
//   req_t{last,valid,ready}  per-requester handshake
//   req_enable               requester may win arbitration (sampled in IDLE)
//   axis_out_*               stream to the encapsulator, tid = requester index
//   trunc_err/trunc_err_id   one-cycle pulse + index when a packet is truncated
// ---------------------------------------------------------------------------
module encap_ingress_arbiter
  import encap_pkg::*;
#(
  parameter  int NUM_REQ           = 4,
  parameter  int AXIS_BUS_WIDTH    = 64,
  parameter  int AXIS_DEST_WIDTH   = 4,
  parameter  int MAX_PACKET_LENGTH = 1522,
  localparam int ID_WIDTH          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int KEEP_WIDTH        = AXIS_BUS_WIDTH / 8
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [NUM_REQ*AXIS_BUS_WIDTH-1:0]    req_tdata,
  input  logic [NUM_REQ*AXIS_DEST_WIDTH-1:0]   req_tdest,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]        req_tkeep,
  input  logic [NUM_REQ-1:0]                   req_tlast,
  input  logic [NUM_REQ-1:0]                   req_tvalid,
  output logic [NUM_REQ-1:0]                   req_tready,
  input  logic [NUM_REQ-1:0]                   req_enable,
  output logic [AXIS_BUS_WIDTH-1:0]            axis_out_tdata,
  output logic [ID_WIDTH-1:0]                  axis_out_tid,
  output logic [AXIS_DEST_WIDTH-1:0]           axis_out_tdest,
  output logic [KEEP_WIDTH-1:0]                axis_out_tkeep,
  output logic                                 axis_out_tlast,
  output logic                                 axis_out_tvalid,
  input  logic                                 axis_out_tready,
  output logic                                 trunc_err,
  output logic [ID_WIDTH-1:0]                  trunc_err_id
);

  localparam int          MAX_BEATS = beats_for_length(MAX_PACKET_LENGTH, KEEP_WIDTH);
  localparam logic [15:0] LIMIT_CNT = 16'(MAX_BEATS - 1);

  arb_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic                trunc_err_q, trunc_err_d;
  logic [ID_WIDTH-1:0] trunc_err_id_q, trunc_err_id_d;

  // Granted slice, selected by grant_q.
  logic [AXIS_BUS_WIDTH-1:0]  sel_data;
  logic [AXIS_DEST_WIDTH-1:0] sel_dest;
  logic [KEEP_WIDTH-1:0]      sel_keep;
  logic                       sel_last;
  logic                       sel_valid;
  logic [NUM_REQ-1:0]         grant_oh;

  logic [ID_WIDTH-1:0] pick_winner;
  logic                pick_any;
  logic                at_limit;
  logic                pass_xfer;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (req_tvalid & req_enable),
    .last_grant (last_grant_q),
    .winner     (pick_winner),
    .any_valid  (pick_any)
  );

  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_data  = '0;
    sel_dest  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_data    = req_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        sel_dest    = req_tdest[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
        sel_keep    = req_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_last    = req_tlast[i];
        sel_valid   = req_tvalid[i];
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign at_limit  = (beat_cnt_q == LIMIT_CNT);
  assign pass_xfer = (state_q == PASS) && sel_valid && axis_out_tready;

  // Output stream and upstream ready. PASS is a zero-latency path from the
  // granted slice; DRAIN keeps the granted source moving with no output.
  always_comb begin
    axis_out_tdata  = sel_data;
    axis_out_tkeep  = sel_keep;
    axis_out_tdest  = sel_dest;
    axis_out_tid    = grant_q;
    axis_out_tvalid = 1'b0;
    axis_out_tlast  = 1'b0;
    req_tready      = '0;
    case (state_q)
      PASS: begin
        axis_out_tvalid = sel_valid;
        axis_out_tlast  = sel_last | at_limit;
        req_tready      = axis_out_tready ? grant_oh : '0;
      end
      DRAIN:   req_tready = grant_oh;
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    beat_cnt_d     = beat_cnt_q;
    trunc_err_d    = 1'b0;
    trunc_err_id_d = trunc_err_id_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d      = pick_winner;
          last_grant_d = pick_winner;
          beat_cnt_d   = '0;
          state_d      = PASS;
        end
      end
      PASS: begin
        if (pass_xfer) begin
          beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
          // tlast on the limit beat is a normal end, not a truncation.
          if (sel_last) begin
            state_d = IDLE;
          end else if (at_limit) begin
            trunc_err_d    = 1'b1;
            trunc_err_id_d = grant_q;
            state_d        = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (sel_valid && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; blocking
  // assignments here would let later statements see half-updated state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt_q     <= '0;
      trunc_err_q    <= 1'b0;
      trunc_err_id_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      beat_cnt_q     <= beat_cnt_d;
      trunc_err_q    <= trunc_err_d;
      trunc_err_id_q <= trunc_err_id_d;
    end
  end

  assign trunc_err    = trunc_err_q;
  assign trunc_err_id = trunc_err_id_q;

endmodule

// File: tb/tb_encap_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// tb_encap_ingress_arbiter
// Per-requester packet queues feed the DUT. At the start of every phase a
// reference model walks those queues with the round-robin rule and the
// length limit and pushes the expected output beats into a scoreboard; a
// separate monitor pops and compares whenever a beat is accepted downstream.
// ---------------------------------------------------------------------------
module tb_encap_ingress_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int BW        = 64;
  localparam int DW        = 4;
  localparam int KW        = BW / 8;
  localparam int IDW       = 2;
  localparam int MAX_BEATS = 191;  // ceil(1522 / 8)

  typedef struct packed {
    logic [BW-1:0] data;
    logic [KW-1:0] keep;
    logic [DW-1:0] dest;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [BW-1:0]  data;
    logic [KW-1:0]  keep;
    logic [DW-1:0]  dest;
    logic [IDW-1:0] tid;
    logic           last;
  } out_t;

  typedef struct packed {
    out_t o;
    logic trunc;  // this beat is a truncation point
  } exp_t;

  logic                    aclk;
  logic                    aresetn;
  logic [NUM_REQ*BW-1:0]   req_tdata;
  logic [NUM_REQ*DW-1:0]   req_tdest;
  logic [NUM_REQ*KW-1:0]   req_tkeep;
  logic [NUM_REQ-1:0]      req_tlast;
  logic [NUM_REQ-1:0]      req_tvalid;
  logic [NUM_REQ-1:0]      req_tready;
  logic [NUM_REQ-1:0]      req_enable;
  logic [BW-1:0]           axis_out_tdata;
  logic [IDW-1:0]          axis_out_tid;
  logic [DW-1:0]           axis_out_tdest;
  logic [KW-1:0]           axis_out_tkeep;
  logic                    axis_out_tlast;
  logic                    axis_out_tvalid;
  logic                    axis_out_tready;
  logic                    trunc_err;
  logic [IDW-1:0]          trunc_err_id;

  encap_ingress_arbiter #(
    .NUM_REQ           (NUM_REQ),
    .AXIS_BUS_WIDTH    (BW),
    .AXIS_DEST_WIDTH   (DW),
    .MAX_PACKET_LENGTH (1522)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .req_tdata       (req_tdata),
    .req_tdest       (req_tdest),
    .req_tkeep       (req_tkeep),
    .req_tlast       (req_tlast),
    .req_tvalid      (req_tvalid),
    .req_tready      (req_tready),
    .req_enable      (req_enable),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tid    (axis_out_tid),
    .axis_out_tdest  (axis_out_tdest),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .trunc_err       (trunc_err),
    .trunc_err_id    (trunc_err_id)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  beat_t src_q [NUM_REQ][$];
  exp_t  exp_q [$];

  int   n_checks = 0;
  int   n_fails  = 0;
  int   model_last = NUM_REQ - 1;
  int   tready_mode = 0;  // 0: always ready, 1: random, 2: toggle
  int   gap_pct = 0;
  bit   mon_en = 1'b0;
  bit   xfer_prev [NUM_REQ];
  bit   first_beat [NUM_REQ];

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.dest = DW'($urandom);
      b.last = (k == len - 1);
      src_q[r].push_back(b);
    end
  endtask

  // Source drivers and downstream ready: inputs change on the falling edge,
  // handshakes are judged just after, before the next rising edge.
  initial begin
    req_tdata = '0; req_tdest = '0; req_tkeep = '0; req_tlast = '0; req_tvalid = '0;
    axis_out_tready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      xfer_prev[i]  = 1'b0;
      first_beat[i] = 1'b1;
    end
    forever begin
      @(negedge aclk);
      case (tready_mode)
        0:       axis_out_tready = 1'b1;
        1:       axis_out_tready = 1'($urandom_range(1));
        default: axis_out_tready = ~axis_out_tready;
      endcase
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_tvalid[i] && !xfer_prev[i]) begin
          // holding the current beat until it is accepted
        end else if (src_q[i].size() == 0) begin
          req_tvalid[i] = 1'b0;
        end else if (!first_beat[i] && ($urandom_range(99) < gap_pct)) begin
          req_tvalid[i] = 1'b0;
        end else begin
          req_tvalid[i]            = 1'b1;
          req_tdata[i*BW +: BW]    = src_q[i][0].data;
          req_tkeep[i*KW +: KW]    = src_q[i][0].keep;
          req_tdest[i*DW +: DW]    = src_q[i][0].dest;
          req_tlast[i]             = src_q[i][0].last;
        end
      end
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        xfer_prev[i] = req_tvalid[i] && req_tready[i];
        if (xfer_prev[i]) begin
          first_beat[i] = src_q[i][0].last;
          void'(src_q[i].pop_front());
        end
      end
    end
  end

  // Monitor: compares accepted output beats against the scoreboard and checks
  // handshake rules, the post-packet bubble and the truncation pulse timing.
  initial begin
    bit   prev_stall = 1'b0;
    bit   bubble_due = 1'b0;
    bit   trunc_due  = 1'b0;
    logic [IDW-1:0] due_id = '0;
    out_t prev_out = '0;
    out_t got;
    exp_t e;
    forever begin
      @(negedge aclk);
      #1;
      if (!mon_en) begin
        prev_stall = 1'b0; bubble_due = 1'b0; trunc_due = 1'b0;
      end else begin
        got = '{data: axis_out_tdata, keep: axis_out_tkeep, dest: axis_out_tdest,
                tid: axis_out_tid, last: axis_out_tlast};
        if (trunc_due) check("trunc_pulse", 128'({trunc_err, trunc_err_id}), 128'({1'b1, due_id}));
        else           check("trunc_quiet", 128'(trunc_err), 128'(0));
        trunc_due = 1'b0;
        if (bubble_due) check("idle_bubble", 128'(axis_out_tvalid), 128'(0));
        bubble_due = 1'b0;
        if (prev_stall) check("stall_hold", 128'({axis_out_tvalid, got}), 128'({1'b1, prev_out}));
        check("tready_onehot", 128'($onehot0(req_tready)), 128'(1));
        if (axis_out_tvalid)
          check("tready_mirror", 128'(req_tready), 128'(NUM_REQ'(axis_out_tready) << axis_out_tid));
        if (axis_out_tvalid && axis_out_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fails++;
            $display("FAIL unexpected_beat: got tid %0d data %0h, expected no beat", axis_out_tid, axis_out_tdata);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", 128'(got), 128'(e.o));
            trunc_due = e.trunc;
            due_id    = e.o.tid;
          end
          bubble_due = axis_out_tlast;
        end
        prev_stall = axis_out_tvalid && !axis_out_tready;
        prev_out   = got;
      end
    end
  end

  // Reference model: packets leave whole in round-robin order among enabled
  // requesters holding packets; anything past MAX_BEATS beats is dropped.
  task automatic build_expected(input logic [NUM_REQ-1:0] en);
    int   pos [NUM_REQ];
    int   r, len;
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) pos[i] = 0;
    forever begin
      r = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c = (model_last + k) % NUM_REQ;
        if (r < 0 && en[c] && pos[c] < src_q[c].size()) r = c;
      end
      if (r < 0) break;
      len = 1;
      while (!src_q[r][pos[r] + len - 1].last) len++;
      for (int b = 0; b < len && b < MAX_BEATS; b++) begin
        e.o.data  = src_q[r][pos[r] + b].data;
        e.o.keep  = src_q[r][pos[r] + b].keep;
        e.o.dest  = src_q[r][pos[r] + b].dest;
        e.o.tid   = IDW'(r);
        e.o.last  = (b == len - 1) || (b == MAX_BEATS - 1);
        e.trunc   = (b == MAX_BEATS - 1) && (len > MAX_BEATS);
        exp_q.push_back(e);
      end
      pos[r] += len;
      model_last = r;
    end
  endtask

  // Called on a rising edge + 2. exp_cycles > 0 also checks the number of
  // cycles until the last beat is accepted and enabled sources are empty.
  task automatic run_phase(input string name, input logic [NUM_REQ-1:0] en,
                           input int mode, input int gap, input int exp_cycles);
    int  cycles = 0;
    bit  busy   = 1'b1;
    req_enable  = en;
    tready_mode = mode;
    gap_pct     = gap;
    build_expected(en);
    while (busy) begin
      @(negedge aclk);
      #2;
      cycles++;
      busy = (exp_q.size() != 0);
      for (int i = 0; i < NUM_REQ; i++) if (en[i] && src_q[i].size() != 0) busy = 1'b1;
      if (busy && cycles > 20000) begin
        n_checks++; n_fails++;
        $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, exp_q.size(), cycles);
        exp_q.delete();
        busy = 1'b0;
      end
    end
    if (exp_cycles > 0) check({name, "_cycles"}, 128'(cycles), 128'(exp_cycles));
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #2;
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].delete();
      xfer_prev[i]  = 1'b0;
      first_beat[i] = 1'b1;
    end
    req_tvalid = '0;
    exp_q.delete();
  endtask

  initial begin
    int n1;
    aresetn    = 1'b0;
    req_enable = '0;
    repeat (3) @(posedge aclk);
    #2;
    check("reset_tvalid", 128'(axis_out_tvalid), 128'(0));
    check("reset_tready", 128'(req_tready), 128'(0));
    check("reset_trunc", 128'(trunc_err), 128'(0));
    aresetn = 1'b1;
    mon_en  = 1'b1;

    // Two simultaneous 3-beat packets: req 0 first, bubble, then req 2.
    add_pkt(0, 3); add_pkt(2, 3);
    run_phase("two_req", 4'b1111, 0, 0, 8);

    // Every requester busy with 1-beat packets: strict rotation.
    for (int k = 0; k < 2; k++) for (int i = 0; i < NUM_REQ; i++) add_pkt(i, 1);
    run_phase("rotate", 4'b1111, 0, 0, 16);

    // Disabled requester 1 is never served, then wins the next IDLE once enabled.
    add_pkt(0, 2); add_pkt(2, 2); add_pkt(3, 2); add_pkt(1, 2);
    n1 = src_q[1].size();
    run_phase("disabled", 4'b1101, 1, 20, 0);
    check("disabled_untouched", 128'(src_q[1].size()), 128'(n1));
    run_phase("enabled", 4'b1111, 0, 0, 3);

    // Over-length packet: truncated at beat 191, 9 beats drained, next follows.
    add_pkt(0, 200); add_pkt(0, 3);
    run_phase("truncate", 4'b1111, 0, 0, 205);
    // Exactly at the limit with tlast is a normal end; one beat over truncates.
    add_pkt(1, MAX_BEATS); add_pkt(3, MAX_BEATS + 1);
    run_phase("limit_edge", 4'b1111, 1, 10, 0);

    // Downstream backpressure toggling every cycle.
    add_pkt(2, 4);
    run_phase("toggle_ready", 4'b1111, 2, 0, 0);

    // Randomised phases; the last one enables everyone to empty the queues.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < NUM_REQ; i++)
        repeat ($urandom_range(3))
          add_pkt(i, ($urandom_range(9) == 0) ? int'($urandom_range(195, 190)) : int'($urandom_range(6, 1)));
      run_phase("random", (p == 5) ? 4'hF : NUM_REQ'($urandom_range(15)), 1, 25, 0);
    end

    // Reset in the middle of a packet from req 0.
    mon_en = 1'b0;
    add_pkt(0, 10);
    req_enable  = 4'b1111;
    tready_mode = 0;
    gap_pct     = 0;
    repeat (4) @(posedge aclk);
    #2;
    aresetn = 1'b0;
    @(posedge aclk);
    #2;
    check("midreset_tvalid", 128'(axis_out_tvalid), 128'(0));
    check("midreset_tready", 128'(req_tready), 128'(0));
    aresetn = 1'b1;
    flush_sources();
    model_last = NUM_REQ - 1;
    mon_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) add_pkt(i, 1);
    run_phase("after_reset", 4'b1111, 0, 0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/encap_ingress_arbiter.md
Name: encap_ingress_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single encapsulator input stream between NUM_REQ per-tenant AXI-Stream sources.
- Stamps tid with the winning requester index, so downstream encap config lookups (encap_sel_id_*) resolve per tenant.
- Enforces per-requester enable and a maximum packet length: over-length packets are truncated and the remainder is drained, so one tenant cannot stall the shared encapsulator.

Parameters:
- NUM_REQ, 4, number of requester streams (2..16)
- AXIS_BUS_WIDTH, 64, tdata width in bits
- AXIS_DEST_WIDTH, 4, tdest width; passed through from the winner
- MAX_PACKET_LENGTH, 1522, byte limit per packet
- ID_WIDTH (local), clog2(NUM_REQ) min 1, width of the output tid
- MAX_BEATS (local), ceil(MAX_PACKET_LENGTH / (AXIS_BUS_WIDTH/8)), beat limit per packet (191 at defaults)

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- req_tdata  in  NUM_REQ*AXIS_BUS_WIDTH  flattened tdata, requester i at slice i
- req_tdest  in  NUM_REQ*AXIS_DEST_WIDTH  flattened tdest
- req_tkeep  in  NUM_REQ*AXIS_BUS_WIDTH/8  flattened tkeep
- req_tlast  in  NUM_REQ  per-requester tlast
- req_tvalid  in  NUM_REQ  per-requester tvalid
- req_tready  out  NUM_REQ  per-requester tready
- req_enable  in  NUM_REQ  config: requester allowed to win arbitration
- axis_out_tdata/tid/tdest/tkeep/tlast/tvalid  out  AXIS_BUS_WIDTH/ID_WIDTH/AXIS_DEST_WIDTH/AXIS_BUS_WIDTH/8/1/1  stream to encapsulator
- axis_out_tready  in  1  downstream ready
- trunc_err  out  1  one-cycle pulse when a packet is truncated
- trunc_err_id  out  ID_WIDTH  requester index of the truncated packet, valid with trunc_err

Behaviour:
- States: IDLE, PASS, DRAIN. Reset: state=IDLE; grant=0; last_grant=NUM_REQ-1; beat_cnt=0; axis_out_tvalid=0; req_tready=0; trunc_err=0.
- IDLE:
  - Candidates are requesters with req_tvalid & req_enable.
  - Search starts at (last_grant+1) mod NUM_REQ and wraps.
  - If any candidate exists: register grant=winner, set last_grant=winner, beat_cnt=0, go to PASS.
  - Outputs in IDLE: axis_out_tvalid=0, all req_tready=0.
  - Result: a one-cycle arbitration bubble per packet.
- PASS:
  - Data path is combinational from the granted slice: tdata, tkeep, tdest, tvalid.
  - tid = grant, zero-extended to ID_WIDTH.
  - req_tready[grant] = axis_out_tready; all other req_tready = 0.
  - Zero latency in PASS.
  - Beat transfer is out_tvalid & out_tready; each transfer increments beat_cnt (16-bit, saturating).
  - Transfer with req_tlast: go to IDLE.
  - Transfer with beat_cnt==MAX_BEATS-1 and no req_tlast:
    - force axis_out_tlast=1 on that beat;
    - pulse trunc_err and set trunc_err_id=grant, both registered and visible next cycle;
    - go to DRAIN.
  - A simultaneous tlast and limit hit is a normal end: no error, go to IDLE.
- DRAIN:
  - axis_out_tvalid=0; req_tready[grant]=1 regardless of axis_out_tready.
  - Beats are discarded until a req_tlast transfer, then go to IDLE.
- req_enable is sampled only in IDLE. Deasserting it mid-packet does not cut the packet; it completes normally.
- req_tvalid dropping mid-packet in PASS stalls the output (out_tvalid=0) with no state change.
- A single active requester still incurs the IDLE bubble between packets.
- Reset mid-packet: immediate return to reset values. Any partial packet downstream is the upstream reset domain's responsibility.
- Output is AXIS-compliant: once out_tvalid=1, data is held stable until accepted, because the granted input is itself AXIS-compliant.

Decomposition:
- Shared package (encap_pkg): state enum arb_state_t {IDLE, PASS, DRAIN}; function beats_for_length(bytes, bus_bytes).
- Sub-module rr_priority_pick (NUM_REQ): request vector plus last_grant in, combinational winner index and any_valid out. Reusable by other tenant arbiters in the NMU.

Test Plan:
1. Reqs 0 and 2 each send a 3-beat packet simultaneously; out_tready=1 -> packet from 0 (tid=0), bubble, packet from 2 (tid=2); 8 cycles total.
2. All 4 reqs continuously valid, 1-beat packets -> grant order 0,1,2,3,0,...; each tid seen once per 8 cycles.
3. req_enable=4'b1101, req 1 valid -> req 1 never granted, req_tready[1]=0 throughout; enabling it mid-run gets it granted at the next IDLE.
4. Req 0 sends a 200-beat packet at defaults -> beat 191 is output with tlast=1; trunc_err pulses with id=0; beats 192–200 are accepted with no output; next packet follows.
5. out_tready toggles 1/0 every cycle during a 4-beat packet -> 4 beats delivered in order over 8 cycles, data stable while stalled, req_tready mirrors out_tready.
6. aresetn low for 1 cycle mid-packet -> next cycle out_tvalid=0 and state=IDLE; arbitration restarts from req 0.
